// File: rtl/mips_pipe_pkg.sv
// mips_pipe_pkg: shared state encoding and defaults for the MEM-stage access controller
package mips_pipe_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ERR  = 2'd2
  } state_t;
  localparam int TIMEOUT_DEF = 15;
endpackage

// File: rtl/sat_counter16.sv
// sat_counter16: 16-bit up counter that holds at all-ones
module sat_counter16 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  output logic [15:0] cnt
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (en && cnt != 16'hFFFF) cnt <= cnt + 16'd1;
endmodule

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: MEM-stage data-memory handshake with pipeline stall/bubble control
module mem_access_ctrl
  import mips_pipe_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_read_in,
  input  logic        mem_write_in,
  input  logic [31:0] addr_in,
  input  logic [31:0] wdata_in,
  input  logic        dmem_ready,
  input  logic [31:0] dmem_rdata,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic        stall,
  output logic        mwb_load,
  output logic        mwb_bubble,
  output logic [31:0] rdata_out,
  output logic        mem_error,
  output logic [15:0] stall_cnt
);
  localparam logic [7:0] WLIM = 8'(TIMEOUT - 1);
  state_t state;
  logic [7:0] wcnt;
  assign stall = (state == ERR) || (state == IDLE && (mem_read_in || mem_write_in)) ||
                 (state == WAIT && !dmem_ready);
  assign mwb_load = 1'b1;
  assign mwb_bubble = stall;
  sat_counter16 u_stall_cnt (.clk(clk), .rst_n(rst_n), .en(stall), .cnt(stall_cnt));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state      <= IDLE;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
      rdata_out  <= '0;
      mem_error  <= 1'b0;
      wcnt       <= '0;
    end else begin
      case (state)
        IDLE:
          if (mem_read_in && mem_write_in) begin
            state     <= ERR;
            mem_error <= 1'b1;
          end else if (mem_read_in || mem_write_in) begin
            state      <= WAIT;
            dmem_req   <= 1'b1;
            dmem_we    <= mem_write_in;
            dmem_addr  <= addr_in;
            dmem_wdata <= wdata_in;
            wcnt       <= '0;
          end
        WAIT:
          // completion wins over a coincident timeout
          if (dmem_ready) begin
            state    <= IDLE;
            dmem_req <= 1'b0;
            wcnt     <= '0;
            if (!dmem_we) rdata_out <= dmem_rdata;
          end else if (wcnt >= WLIM) begin
            state     <= ERR;
            dmem_req  <= 1'b0;
            mem_error <= 1'b1;
          end else wcnt <= wcnt + 8'd1;
        ERR: dmem_req <= 1'b0;
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: directed checks of the MEM-stage access controller with TIMEOUT=4
module tb_mem_access_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mem_read_in = 1'b0, mem_write_in = 1'b0;
  logic [31:0] addr_in = '0, wdata_in = '0;
  logic        dmem_ready = 1'b0;
  logic [31:0] dmem_rdata = '0;
  logic        dmem_req, dmem_we, stall, mwb_load, mwb_bubble, mem_error;
  logic [31:0] dmem_addr, dmem_wdata, rdata_out;
  logic [15:0] stall_cnt;
  int n_chk = 0, n_fail = 0;

  mem_access_ctrl #(.TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n), .mem_read_in(mem_read_in), .mem_write_in(mem_write_in),
    .addr_in(addr_in), .wdata_in(wdata_in), .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .stall(stall), .mwb_load(mwb_load), .mwb_bubble(mwb_bubble), .rdata_out(rdata_out),
    .mem_error(mem_error), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset;
    #2 rst_n = 1'b0;
    #1 rst_n = 1'b1;
  endtask

  task automatic check_reset_vals;
    check("rst_req", 32'(dmem_req), 0);
    check("rst_we", 32'(dmem_we), 0);
    check("rst_addr", dmem_addr, 0);
    check("rst_wdata", dmem_wdata, 0);
    check("rst_rdata", rdata_out, 0);
    check("rst_err", 32'(mem_error), 0);
    check("rst_scnt", 32'(stall_cnt), 0);
    check("rst_stall", 32'(stall), 0);
  endtask

  initial begin
    #12;
    check_reset_vals();
    rst_n = 1'b1;
    // idle: five cycles with no memory op
    for (int i = 0; i < 5; i++) begin
      tick();
      check("idle_stall", 32'(stall), 0);
      check("idle_load", 32'(mwb_load), 1);
      check("idle_req", 32'(dmem_req), 0);
    end
    check("idle_scnt", 32'(stall_cnt), 0);
    // single-cycle load
    mem_read_in = 1'b1; addr_in = 32'h40;
    #1;
    check("ld_issue_stall", 32'(stall), 1);
    check("ld_issue_bubble", 32'(mwb_bubble), 1);
    tick();
    mem_read_in = 1'b0; addr_in = '0;
    check("ld_req", 32'(dmem_req), 1);
    check("ld_we", 32'(dmem_we), 0);
    check("ld_addr", dmem_addr, 32'h40);
    dmem_ready = 1'b1; dmem_rdata = 32'hDEAD_BEEF;
    #1;
    check("ld_done_stall", 32'(stall), 0);
    check("ld_done_bubble", 32'(mwb_bubble), 0);
    check("ld_done_load", 32'(mwb_load), 1);
    tick();
    dmem_ready = 1'b0; dmem_rdata = '0;
    check("ld_rdata", rdata_out, 32'hDEAD_BEEF);
    check("ld_req_clr", 32'(dmem_req), 0);
    check("ld_scnt", 32'(stall_cnt), 1);
    // store with three unready WAIT cycles; the fourth coincides with the timeout
    mem_write_in = 1'b1; addr_in = 32'h10; wdata_in = 32'h1234_5678;
    #1;
    check("st_issue_stall", 32'(stall), 1);
    tick();
    mem_write_in = 1'b0; addr_in = 32'hFFFF_FFFF; wdata_in = '0; mem_read_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("st_req", 32'(dmem_req), 1);
      check("st_we", 32'(dmem_we), 1);
      check("st_addr", dmem_addr, 32'h10);
      check("st_wdata", dmem_wdata, 32'h1234_5678);
      check("st_stall", 32'(stall), 1);
      tick();
    end
    mem_read_in = 1'b0;
    dmem_ready = 1'b1; dmem_rdata = 32'hCAFE_F00D;
    #1;
    check("st_done_stall", 32'(stall), 0);
    check("st_done_addr", dmem_addr, 32'h10);
    tick();
    dmem_ready = 1'b0;
    check("st_rdata_kept", rdata_out, 32'hDEAD_BEEF);
    check("st_scnt", 32'(stall_cnt), 5);
    check("st_req_clr", 32'(dmem_req), 0);
    check("st_err", 32'(mem_error), 0);
    // ready outside WAIT is ignored
    dmem_ready = 1'b1;
    #1;
    check("idle_rdy_stall", 32'(stall), 0);
    tick();
    dmem_ready = 1'b0;
    check("idle_rdy_rdata", rdata_out, 32'hDEAD_BEEF);
    check("idle_rdy_req", 32'(dmem_req), 0);
    // timeout: load never completes
    mem_read_in = 1'b1; addr_in = 32'h80;
    tick();
    mem_read_in = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("to_wait_req", 32'(dmem_req), 1);
      check("to_wait_stall", 32'(stall), 1);
      check("to_wait_err", 32'(mem_error), 0);
      tick();
    end
    check("to_err", 32'(mem_error), 1);
    check("to_req", 32'(dmem_req), 0);
    check("to_stall", 32'(stall), 1);
    check("to_bubble", 32'(mwb_bubble), 1);
    check("to_scnt", 32'(stall_cnt), 10);
    dmem_ready = 1'b1;
    tick();
    tick();
    dmem_ready = 1'b0;
    check("err_hold_err", 32'(mem_error), 1);
    check("err_hold_stall", 32'(stall), 1);
    check("err_hold_req", 32'(dmem_req), 0);
    check("err_hold_scnt", 32'(stall_cnt), 12);
    // illegal: read and write together
    pulse_reset();
    check("ill_rst_err", 32'(mem_error), 0);
    mem_read_in = 1'b1; mem_write_in = 1'b1;
    #1;
    check("ill_stall", 32'(stall), 1);
    check("ill_req0", 32'(dmem_req), 0);
    tick();
    mem_read_in = 1'b0; mem_write_in = 1'b0;
    check("ill_err", 32'(mem_error), 1);
    check("ill_req1", 32'(dmem_req), 0);
    tick();
    check("ill_req2", 32'(dmem_req), 0);
    check("ill_stall2", 32'(stall), 1);
    // reset during the second WAIT cycle, then a normal load
    pulse_reset();
    mem_read_in = 1'b1; addr_in = 32'h200; wdata_in = 32'h5555_AAAA;
    tick();
    mem_read_in = 1'b0;
    tick();
    check("mid_req", 32'(dmem_req), 1);
    #2 rst_n = 1'b0;
    #1;
    check_reset_vals();
    rst_n = 1'b1;
    mem_read_in = 1'b1; addr_in = 32'h44;
    tick();
    mem_read_in = 1'b0;
    check("post_req", 32'(dmem_req), 1);
    check("post_addr", dmem_addr, 32'h44);
    dmem_ready = 1'b1; dmem_rdata = 32'h0BAD_F00D;
    tick();
    dmem_ready = 1'b0;
    check("post_rdata", rdata_out, 32'h0BAD_F00D);
    check("post_scnt", 32'(stall_cnt), 1);
    check("post_req_clr", 32'(dmem_req), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 15, meaning the maximum WAIT-state cycles before an access is declared failed (legal range 1..255).
REQ-002 SHALL have port clk  in  1  single system clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n  in  1  asynchronous active-low reset.
REQ-004 SHALL have ports mem_read_in, mem_write_in  in  1 each  memory-op decode of the instruction in the MEM stage.
REQ-005 SHALL have ports addr_in, wdata_in  in  32 each  MEM-stage address and store data.
REQ-006 SHALL have port dmem_ready  in  1  data-memory completion strobe.
REQ-007 SHALL have port dmem_rdata  in  32  data-memory read data, valid with dmem_ready.
REQ-008 SHALL have ports dmem_req, dmem_we  out  1 each  memory request and write select.
REQ-009 SHALL have ports dmem_addr, dmem_wdata  out  32 each  registered request address and store data.
REQ-010 SHALL have port stall  out  1  freeze for the PC, IF/ID, ID/EX and EX/MEM registers.
REQ-011 SHALL have port mwb_load  out  1  load enable for the MEM/WB pipeline register.
REQ-012 SHALL have port mwb_bubble  out  1  forces write_back low into MEM/WB (inserts a bubble).
REQ-013 SHALL have port rdata_out  out  32  captured load data feeding the MEM/WB read-data input.
REQ-014 SHALL have ports mem_error  out  1  (sticky failure flag) and stall_cnt  out  16  (saturating count of stall cycles).

Function
REQ-015 SHALL implement the states IDLE, WAIT and ERR.
REQ-016 In IDLE with neither op asserted, SHALL drive stall=0, mwb_load=1, mwb_bubble=0 and dmem_req=0.
REQ-017 In IDLE with exactly one op asserted, SHALL drive stall=1, mwb_load=1 and mwb_bubble=1; register dmem_addr/dmem_wdata, set dmem_we=mem_write_in; set dmem_req=1 from the next edge; go to WAIT.
REQ-018 In WAIT, SHALL keep dmem_req, dmem_we, dmem_addr and dmem_wdata stable and ignore MEM-stage input changes.
REQ-019 In WAIT with dmem_ready=0, SHALL drive stall=1, mwb_load=1, mwb_bubble=1 and increment the 8-bit wait counter.
REQ-020 In WAIT with dmem_ready=1, SHALL drive stall=0, mwb_load=1 and mwb_bubble=0 that same cycle; capture dmem_rdata into rdata_out (reads only; writes leave rdata_out unchanged); clear dmem_req at the edge; clear the wait counter; return to IDLE.
REQ-021 Minimum access latency SHALL be exactly one stall cycle (op in cycle N, ready in N+1, pipeline advances at end of N+1).
REQ-022 The wait counter reaching TIMEOUT with dmem_ready=0 SHALL move to ERR; dmem_ready and timeout in the same cycle SHALL resolve as completion.
REQ-023 Both mem_read_in and mem_write_in high in IDLE SHALL be illegal; SHALL go directly to ERR with no dmem_req issued.
REQ-024 In ERR, SHALL set mem_error=1, dmem_req=0, stall=1, mwb_load=1, mwb_bubble=1; only reset exits ERR.
REQ-025 dmem_ready outside WAIT SHALL be ignored.
REQ-026 stall_cnt SHALL increment on every cycle with stall=1 and saturate at 16'hFFFF.
REQ-027 stall, mwb_load and mwb_bubble SHALL be combinational from state and inputs; all other outputs SHALL be registered.

Reset
REQ-028 rst_n low SHALL immediately force IDLE, dmem_req=0, dmem_we=0, dmem_addr=0, dmem_wdata=0, rdata_out=0, mem_error=0, stall_cnt=0 and wait counter=0, including mid-access; any abandoned access is not replayed.
REQ-029 After rst_n rises, the first rising edge of clk SHALL be evaluated normally from IDLE.

Structure
REQ-030 The state encoding (IDLE=2'd0, WAIT=2'd1, ERR=2'd2) and the default TIMEOUT constant SHALL reside in shared package mips_pipe_pkg.
REQ-031 The saturating stall counter SHALL be one sub-module, sat_counter16; everything else SHALL be flat.

Verification
REQ-032 Bench SHALL cover: no mem op for 5 cycles -> stall=0, mwb_load=1 every cycle, dmem_req never 1, stall_cnt=0.
REQ-033 Bench SHALL cover: load addr 0x0000_0040, dmem_ready in the first WAIT cycle with rdata 0xDEAD_BEEF -> exactly 1 stall cycle, rdata_out=0xDEAD_BEEF, stall_cnt=1.
REQ-034 Bench SHALL cover: store addr 0x10, wdata 0x1234_5678, ready after 3 WAIT cycles -> dmem_we=1, addr/data stable throughout, 4 stall cycles, rdata_out unchanged.
REQ-035 Bench SHALL cover: TIMEOUT=4 with ready never asserted -> ERR after 4 WAIT cycles, mem_error=1, dmem_req=0, stall held high.
REQ-036 Bench SHALL cover: mem_read_in and mem_write_in both 1 -> ERR next cycle, dmem_req never asserted.
REQ-037 Bench SHALL cover: rst_n pulled low in the second WAIT cycle -> all outputs at reset values without a clock edge, then a normal load completes.
